// File: rtl/slc3_mem_ctrl.sv
// SLC-3 memory-access controller: turns level-held Mem_OE/Mem_WE requests into
// single-shot BRAM accesses with fixed read latency, and maps 16'hFFFF to switches/hex.
module slc3_mem_ctrl #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [15:0]       MAR,
    input  logic [15:0]       MDR,
    input  logic [15:0]       SW,
    output logic [15:0]       data_to_cpu,
    output logic              mem_ready,
    output logic [15:0]       hex_reg,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [15:0]       bram_dina,
    input  logic [15:0]       bram_douta
);

    typedef enum logic [2:0] {
        StIdle,
        StRdW1,
        StRdW2,
        StRdValid,
        StWrHold
    } state_e;

    state_e r_state;
    logic   r_is_io;
    logic   w_is_io;
    logic   w_idle;

    // BRAM strobes only fire in the request cycle, so a held request never repeats them.
    always_comb begin
        w_is_io   = (MAR == 16'hFFFF);
        w_idle    = (r_state == StIdle) && !Reset;
        bram_ena  = w_idle && (Mem_WE || Mem_OE) && !w_is_io;
        bram_wea  = w_idle && Mem_WE && !w_is_io;
        bram_addr = MAR[ADDR_W-1:0];
        bram_dina = MDR;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= StIdle;
            r_is_io     <= 1'b0;
            mem_ready   <= 1'b0;
            data_to_cpu <= 16'h0000;
            hex_reg     <= 16'h0000;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_is_io <= w_is_io;
                    if (Mem_WE) begin
                        r_state   <= StWrHold;
                        mem_ready <= 1'b1;
                        if (w_is_io) begin
                            hex_reg <= MDR;
                        end
                    end else if (Mem_OE) begin
                        r_state <= StRdW1;
                    end
                end
                StRdW1: begin
                    r_state <= Mem_OE ? StRdW2 : StIdle;
                end
                StRdW2: begin
                    if (Mem_OE) begin
                        r_state     <= StRdValid;
                        mem_ready   <= 1'b1;
                        data_to_cpu <= r_is_io ? SW : bram_douta;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StRdValid: begin
                    if (!Mem_OE) begin
                        r_state   <= StIdle;
                        mem_ready <= 1'b0;
                    end
                end
                StWrHold: begin
                    if (!Mem_WE) begin
                        r_state   <= StIdle;
                        mem_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    mem_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
